// File: rtl/fetch_decode_if.sv
// Fetch/decode bus: PC unit and instruction memory on the master side,
// the fetch_decode front end on the slave side.
interface fetch_decode_if;
  logic [15:0] PCIN;
  logic [15:0] STAGEIN;
  logic [15:0] STAGEOUT;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_EN;
  logic [15:0] IMEM_RDATA;
  logic        FETCHED;
  logic        ID_VALID;
  logic [15:0] ID_INSTR;
  logic [15:0] ID_PC;
  logic        READREG;
  logic [3:0]  READREG1;
  logic [3:0]  READREG2;
  logic        WILLWRITE;
  logic [3:0]  STARTREG;
  logic        ILLEGAL;
  logic        HALTED;

  modport master (
    output PCIN, STAGEIN, STAGEOUT, IMEM_RDATA,
    input  IMEM_ADDR, IMEM_EN, FETCHED, ID_VALID, ID_INSTR, ID_PC,
           READREG, READREG1, READREG2, WILLWRITE, STARTREG, ILLEGAL, HALTED
  );

  modport slave (
    input  PCIN, STAGEIN, STAGEOUT, IMEM_RDATA,
    output IMEM_ADDR, IMEM_EN, FETCHED, ID_VALID, ID_INSTR, ID_PC,
           READREG, READREG1, READREG2, WILLWRITE, STARTREG, ILLEGAL, HALTED
  );
endinterface

// File: rtl/fetch_decode.sv
// Instruction fetch and decode front end of the 16-bit core: issues fetches
// from the PC unit's PC, holds the returned word in decode, emits hazard requests.
module fetch_decode #(
  parameter int PRIME_CYCLES = 2
) (
  input logic          CLK,
  input logic          RST_N,
  fetch_decode_if.slave bus
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] PRIME_LAST = 4'(PRIME_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        f_valid_q, f_valid_d;
  logic [15:0] f_pc_q, f_pc_d;
  logic        fetched_q, fetched_d;
  logic        id_valid_q, id_valid_d;
  logic        id_first_q, id_first_d;
  logic [15:0] id_instr_q, id_instr_d;
  logic [15:0] id_pc_q, id_pc_d;

  logic        kill;
  logic        halt_in_id;
  logic        imem_en;
  logic        load_id;
  logic [3:0]  op, rd, rs, rt;

  assign op = id_instr_q[15:12];
  assign rd = id_instr_q[11:8];
  assign rs = id_instr_q[7:4];
  assign rt = id_instr_q[3:0];

  assign kill       = (bus.STAGEIN == 16'h0000) || (bus.STAGEOUT == 16'h0000);
  assign halt_in_id = id_valid_q && (op == 4'hF);
  assign imem_en    = (state_q == S_RUN) && !kill && !halt_in_id;
  assign load_id    = f_valid_q && !kill;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: begin
        state_d = S_PRIME;
        cnt_d   = 4'd0;
      end
      S_PRIME: begin
        if (cnt_q == PRIME_LAST) state_d = S_RUN;
        else                     cnt_d   = cnt_q + 4'd1;
      end
      S_RUN:   if (halt_in_id && !kill) state_d = S_HALT;
      // A kill while halted means an older branch flushed the pipe.
      S_HALT:  if (kill) state_d = S_RUN;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    f_valid_d  = imem_en;
    f_pc_d     = imem_en ? bus.PCIN : f_pc_q;
    fetched_d  = f_valid_d;
    id_first_d = load_id;
    id_instr_d = load_id ? bus.IMEM_RDATA : id_instr_q;
    id_pc_d    = load_id ? f_pc_q : id_pc_q;
    if (kill)         id_valid_d = 1'b0;
    else if (load_id) id_valid_d = 1'b1;
    else              id_valid_d = id_valid_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_RESET;
      cnt_q      <= 4'd0;
      f_valid_q  <= 1'b0;
      f_pc_q     <= 16'h0000;
      fetched_q  <= 1'b0;
      id_valid_q <= 1'b0;
      id_first_q <= 1'b0;
      id_instr_q <= 16'h0000;
      id_pc_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f_valid_q  <= f_valid_d;
      f_pc_q     <= f_pc_d;
      fetched_q  <= fetched_d;
      id_valid_q <= id_valid_d;
      id_first_q <= id_first_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  logic       rd_en, wr_en, ill;
  logic [3:0] r1, r2;

  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    ill   = 1'b0;
    r1    = 4'd0;
    r2    = 4'd0;
    if (id_valid_q) begin
      case (op)
        4'h0, 4'hC, 4'hF: ;
        4'h8: wr_en = 1'b1;
        4'h9: begin rd_en = 1'b1; r2 = rs; wr_en = 1'b1; end
        4'hA: begin rd_en = 1'b1; r1 = rs; r2 = rd; end
        4'hB: begin rd_en = 1'b1; r1 = rd; r2 = rs; end
        4'hD, 4'hE: ill = 1'b1;
        default: begin rd_en = 1'b1; r1 = rs; r2 = rt; wr_en = 1'b1; end
      endcase
    end
  end

  // Reservation and illegal flag fire only on the first live cycle so a held word never repeats them.
  assign bus.WILLWRITE = wr_en && id_first_q;
  assign bus.STARTREG  = (wr_en && id_first_q) ? rd : 4'd0;
  assign bus.ILLEGAL   = ill && id_first_q;
  assign bus.READREG   = rd_en;
  assign bus.READREG1  = r1;
  assign bus.READREG2  = r2;

  assign bus.IMEM_ADDR = bus.PCIN;
  assign bus.IMEM_EN   = imem_en;
  assign bus.FETCHED   = fetched_q;
  assign bus.ID_VALID  = id_valid_q;
  assign bus.ID_INSTR  = id_instr_q;
  assign bus.ID_PC     = id_pc_q;
  assign bus.HALTED    = (state_q == S_HALT);

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode front end of the 16-bit pipelined core. It drives the synchronous instruction memory from the PC unit's PC output and acknowledges each issued fetch back to the PC unit. It decodes the returned word into register-read and register-write hazard requests, and obeys the PC unit's stage-1 kill masks, which signal both flushes and stalls.

## Interface
- PRIME_CYCLES, default 2: idle cycles after reset release before the first fetch; legal range 1..15.
- CLK  in  1  single clock. State updates on posedge; the PC unit updates on negedge.
- RST_N  in  1  asynchronous, active-low reset.
- PCIN  in  16  current PC from the PC unit.
- STAGEIN  in  16  stage-1 input mask: 16'hFFFF advance, 16'h0000 kill.
- STAGEOUT  in  16  stage-1 output mask, same encoding as STAGEIN.
- IMEM_ADDR  out  16  combinational, equal to PCIN.
- IMEM_EN  out  1  combinational fetch request.
- IMEM_RDATA  in  16  memory word, valid in the cycle after the posedge that sampled IMEM_EN=1.
- FETCHED  out  1  registered one-cycle acknowledge; the PC unit increments on the following negedge.
- ID_VALID  out  1  the decode register holds a live instruction.
- ID_INSTR  out  16  decoded instruction word.
- ID_PC  out  16  PC of the decoded instruction.
- READREG, READREG1[3:0], READREG2[3:0]  out  source-register hazard query.
- WILLWRITE, STARTREG[3:0]  out  destination-register reservation.
- ILLEGAL  out  1  one-cycle pulse when a reserved opcode reaches decode.
- HALTED  out  1  high while the FSM is in HALT.

## Operation
- Instruction fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
- Kill condition: `kill = (STAGEIN==0) || (STAGEOUT==0)`, sampled at posedge.
- FSM states: RESET, PRIME, RUN, HALT.
  - RESET → PRIME on the first posedge after RST_N rises.
  - PRIME counts PRIME_CYCLES posedges, then moves to RUN.
  - RUN → HALT when a live HALT (op=1111) is in decode and kill=0.
  - HALT → RUN on any kill, because an older branch has flushed the pipe.
- `IMEM_EN = (state==RUN) && !kill && !(ID_VALID && op==1111)`.
- At a posedge with IMEM_EN=1, the fetch slot loads F_VALID=1 and F_PC=PCIN. Otherwise F_VALID=0.
- FETCHED is the registered copy of F_VALID's next-state value, so it is high for exactly the cycle following an issue posedge.
- At a posedge with F_VALID=1 and kill=0, the decode register loads ID_INSTR=IMEM_RDATA, ID_PC=F_PC, ID_VALID=1.
- At a posedge with kill=1, the block clears F_VALID, ID_VALID and FETCHED, and issues nothing.
- Decode outputs are combinational from the decode register, gated by ID_VALID:
  - op 0000: NOP. No read, no write.
  - op 0001–0111: ALU. Read rs and rt, write rd.
  - op 1000: LI. Write rd; no read.
  - op 1001: LW. Read rs (READREG2=rs), write rd.
  - op 1010: SW. Read rs and rd (READREG1=rs, READREG2=rd); no write.
  - op 1011: BEQ. Read rd and rs; no write.
  - op 1100: JMP. No read, no write.
  - op 1101, 1110: reserved. Treated as NOP; ILLEGAL pulses.
  - op 1111: HALT. No read, no write.
- READREG=1 only for ops that read. READREG1 and READREG2 are 0 otherwise.
- WILLWRITE=1 only for ops that write, with STARTREG=rd, and only during the first cycle the instruction is live in decode; a held instruction does not re-reserve.
- A killed instruction never asserts WILLWRITE after the kill posedge.

## Timing
- Reset values: FETCHED=0, ID_VALID=0, ID_INSTR=0, ID_PC=0, ILLEGAL=0, HALTED=0, IMEM_EN=0, state=RESET, F_VALID=0.
- Asserting RST_N low mid-operation clears all state immediately, including any in-flight fetch.
- First IMEM_EN occurs PRIME_CYCLES+1 posedges after RST_N release.
- Fetch-to-decode latency is 1 cycle. Throughput is 1 fetch per cycle.
- A kill sampled at posedge k:
  - the fetch returning in cycle k is dropped;
  - no issue happens at k;
  - the next issue is at k+1 from the rewound PCIN.
- Kill held for N cycles produces N cycles with no issue and no decode.
- HALT in decode with a simultaneous kill: the kill wins, ID_VALID clears, and the FSM stays in RUN.
- PC wrap: FFFF→0000 is the PC unit's responsibility; this block passes any PCIN unchanged.

## Test plan
- **Reset and prime:** with PRIME_CYCLES=2 and memory {0:1123, 1:8105, 2:0000}:
  - first IMEM_EN at the 3rd posedge after release, with IMEM_ADDR=0;
  - ID_INSTR=1123 one cycle later, with READREG1=2, READREG2=3, WILLWRITE=1, STARTREG=1.
- **Streaming:** 8 consecutive fetches produce FETCHED high for 8 consecutive cycles and ID_PC incrementing 0..7.
- **Flush:** masks go to 0 for 1 cycle while PC 5 is in decode:
  - ID_VALID=0 next cycle;
  - no WILLWRITE for PC 5 or PC 6;
  - the next IMEM_ADDR equals the new PCIN (e.g. 0040).
- **Stall/replay:** masks go to 0 for 2 cycles with PCIN rewound to 3:
  - zero FETCHED pulses during the kill;
  - the instruction at 3 is re-decoded and WILLWRITE pulses once.
- **HALT:**
  - word F000 in decode → HALTED=1 and IMEM_EN=0 indefinitely;
  - a later 1-cycle kill → RUN, with fetch resuming at PCIN;
  - word D000 in decode → ILLEGAL pulse with READREG=0 and WILLWRITE=0.
- **Async reset mid-stream:** RST_N low between edges → all outputs 0 immediately; after release, the prime sequence restarts.
